// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline: load-use hazards,
// taken-branch/jump redirects, multi-cycle MUL/DIV occupancy of EX and
// data-memory wait states. Enables and flushes are combinational.
//
// Optional build: define PIPE_HAZARD_PERF_EN to add the perf_stall_cnt and
// perf_flush_cnt ports and their counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no MUL/DIV in flight; a MUL/DIV in EX with L>1 launches here
// BUSY  | MUL/DIV occupying EX; cnt counts remaining busy cycles
// DONE  | final EX cycle; EX/MEM captures the result, no relaunch

module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_is_mul,
    input  logic       ex_is_div,
    input  logic       ex_redirect,
    input  logic       dmem_wait,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       md_start,
    output logic       md_busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             md_launch;
    logic             load_use;

    // Latency selection, launch condition and load-use detection (x0 never hazards)
    always_comb begin
        lat       = ex_is_mul ? MUL_L : DIV_L;
        md_launch = (state == IDLE) && (ex_is_mul || ex_is_div) && (lat > CNT_W'(1));
        load_use  = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Priority-ordered enable/flush generation
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_start     = 1'b0;
        md_busy      = (state == BUSY) && !sync_rst;
        if (sync_rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (dmem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if ((state == BUSY) || md_launch) begin
            // EX is occupied: freeze the front end, push a bubble into MEM
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            md_start     = md_launch;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // MUL/DIV occupancy FSM and down-counter; dmem_wait freezes everything
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!dmem_wait) begin
            case (state)
                IDLE: begin
                    if (md_launch) begin
                        cnt   <= lat - CNT_W'(2);
                        state <= (lat == CNT_W'(2)) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    // cnt==0 cannot occur in BUSY; treat it as the last cycle anyway
                    if (cnt <= CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Stall cycles and honoured redirects; if_id_flush outside reset only comes from a redirect
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline (IF, ID, EX, MEM, WB).
- Drives the `en` and `sync_rst` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle MUL/DIV occupancy of EX, and data-memory wait states.
- Contains the MUL/DIV occupancy FSM and its cycle counter.

Parameters:
- MUL_CYCLES, 4: total EX occupancy of MUL/MULH/MULHSU/MULHU in cycles. Range 1..63; 1 means no stall.
- DIV_CYCLES, 33: total EX occupancy of DIV/DIVU/REM/REMU in cycles. Range 1..63; 1 means no stall.
- CNT_W, 6: width of the MUL/DIV down-counter; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- sync_rst  input  1  synchronous, active-high reset.
- id_rs1  input  5  rs1 index of the instruction in ID.
- id_rs2  input  5  rs2 index of the instruction in ID.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_is_load  input  1  EX holds a load.
- ex_is_mul  input  1  EX holds a MUL-class instruction.
- ex_is_div  input  1  EX holds a DIV/REM-class instruction.
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR.
- dmem_wait  input  1  data memory not ready for the MEM-stage access.
- pc_en  output  1  PC register enable.
- if_id_en  output  1  IF/ID register `en`.
- id_ex_en  output  1  ID/EX register `en`.
- ex_mem_en  output  1  EX/MEM register `en`.
- mem_wb_en  output  1  MEM/WB register `en`.
- if_id_flush  output  1  IF/ID register `sync_rst`.
- id_ex_flush  output  1  ID/EX register `sync_rst`.
- ex_mem_flush  output  1  EX/MEM register `sync_rst`.
- md_start  output  1  one-cycle start pulse to the MUL/DIV unit.
- md_busy  output  1  FSM is in BUSY.

Behaviour:
- State: FSM {IDLE, BUSY, DONE} plus the down-counter `cnt` [CNT_W-1:0].
- Reset: while sync_rst=1, next state is IDLE and next cnt is 0.
  - All `*_en` outputs are 1.
  - All `*_flush` outputs are 1.
  - md_start=0, md_busy=0.
  - Reset asserted mid-BUSY aborts the operation; no md_start is issued.
- Outputs are combinational from state and inputs. Zero-cycle latency from hazard inputs to enables and flushes.
- Evaluate the following in priority order; the first matching rule wins.
  1. dmem_wait=1:
     - All five enables are 0 and all flushes are 0; the whole pipe freezes.
     - FSM and cnt hold.
     - md_start is suppressed; the MUL/DIV launch is deferred until dmem_wait drops.
  2. FSM=BUSY:
     - pc_en, if_id_en and id_ex_en are 0.
     - ex_mem_en=1 and ex_mem_flush=1, so a bubble enters MEM.
     - mem_wb_en=1.
     - cnt decrements each cycle; at cnt==1 the next state is DONE.
  3. FSM=IDLE with (ex_is_mul or ex_is_div) and latency L>1, where L is MUL_CYCLES if ex_is_mul, else DIV_CYCLES:
     - md_start=1; outputs are as in BUSY.
     - Next state is BUSY with cnt=L-2; if L==2 the next state is DONE directly.
  4. ex_redirect=1:
     - if_id_flush=1 and id_ex_flush=1; all enables are 1.
     - This overrides a simultaneous load-use hazard.
  5. Load-use, i.e. ex_is_load AND ex_rd!=0 AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)):
     - pc_en=0 and if_id_en=0.
     - id_ex_en=1 and id_ex_flush=1 (bubble inserted).
     - ex_mem_en=1 and mem_wb_en=1.
  6. Otherwise: all enables are 1 and all flushes are 0.
- DONE state:
  - Lasts exactly one cycle. Normal rules 4–6 apply, and rule 3 is NOT re-triggered for the same instruction.
  - EX/MEM captures the result.
  - Next state is IDLE, unless dmem_wait=1, in which case DONE holds.
- Total EX occupancy of a MUL/DIV instruction is exactly L cycles when no dmem_wait occurs.
- md_busy=1 only in BUSY.
- x0 is never a hazard source.
- Instruction types are assumed one-hot: mul, div, load and redirect are never asserted together.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, the block adds:
  - Output `perf_stall_cnt` (32 bits): counts cycles with pc_en=0.
  - Output `perf_flush_cnt` (32 bits): counts cycles with ex_redirect honoured.
  - Both counters reset to 0 on sync_rst and wrap modulo 2^32.
- When undefined, neither port nor counter exists and the ports are omitted.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_use_rs2=1, id_rs2=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd=0 -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, all enables 1.
- DIV with DIV_CYCLES=33 -> md_start=1 for exactly 1 cycle; pc_en low for exactly 32 cycles; then DONE with ex_mem_en=1 and ex_mem_flush=0; back to IDLE.
- MUL with MUL_CYCLES=4 and dmem_wait=1 held for 3 cycles during BUSY -> all enables 0 and cnt frozen; total stall is 3+3=6 cycles.
- sync_rst asserted at the 10th cycle of a DIV -> next cycle md_busy=0 and state IDLE; no further md_start.
- PIPE_HAZARD_PERF_EN defined: 2 load-use stalls plus 1 redirect -> perf_stall_cnt=2, perf_flush_cnt=1.
